adc_uart_framer: RTL and testbench
==================================

Name: adc_uart_framer

Overview:
- Consumes the eight 12-bit channel outputs of the ADC controller.
- At a fixed sample rate, picks one channel, captures its value and serialises it into a 2-byte frame.
- Frames go out over a valid/ready byte handshake to the UART transmitter.
- Sits between the ADC controller and the UART TX. Owns sample-rate timing, frame packing and overrun accounting.

Parameters:
- CLK_HZ, 50000000, CLOCK frequency in Hz.
- SAMPLE_HZ, 8000, frame start rate in Hz.
- DIV = CLK_HZ/SAMPLE_HZ, derived localparam (6250 at defaults), minimum 4. Elaboration error if below 4.

Ports:
- CLOCK  in  1  system clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  1 = generate sample ticks.
- CH_SEL  in  3  channel to capture (0..7), sampled at each tick.
- CH0..CH7  in  12 each  ADC channel values, treated as stable registers.
- TX_DATA  out  8  byte offered to the UART.
- TX_VALID  out  1  TX_DATA is valid.
- TX_READY  in  1  UART accepts byte this cycle.
- BUSY  out  1  frame in progress (state != IDLE).
- DROP_CNT  out  8  count of ticks dropped due to overrun, saturating.

Behaviour:

Reset:
- Asserted RESET asynchronously clears: divider counter=0, state=IDLE, sample reg=0, TX_DATA=0x00, TX_VALID=0, BUSY=0, DROP_CNT=0.
- Reset mid-frame abandons the frame; no partial byte is re-sent after release.

Divider:
- Counter counts 0..DIV-1 while ENABLE=1 and wraps to 0.
- tick = ENABLE & (counter==DIV-1), combinational.
- ENABLE=0 holds counter at 0 and produces no ticks. A frame already in progress still completes.
- First tick comes DIV cycles after ENABLE rises.

Frame format (s = captured 12-bit sample):
- byte0 = {1'b1, 1'b0, s[11:6]}
- byte1 = {1'b0, 1'b0, s[5:0]}
- Bit7 is the sync flag. Receiver realigns on bit7=1.

State machine (IDLE, SEND_HI, SEND_LO):
- IDLE: on tick, capture CHn for n=CH_SEL into sample reg and go to SEND_HI. TX_VALID=1 and TX_DATA=byte0 from the next cycle (latency 1 cycle from tick edge).
- SEND_HI: hold TX_DATA=byte0 and TX_VALID=1 until TX_VALID&TX_READY at a rising edge. Then TX_DATA=byte1 next cycle and go to SEND_LO. TX_VALID stays 1 (no bubble).
- SEND_LO: hold byte1 until accepted.
  - On accept with no tick, go to IDLE with TX_VALID=0.
  - On accept in the same cycle as a tick, capture the new sample and go directly to SEND_HI with byte0 of the new sample. This is not a drop.

Handshake and overrun:
- TX_DATA never changes while TX_VALID=1 and TX_READY=0.
- TX_VALID never deasserts without an accept, except on reset.
- A tick in SEND_HI, or in SEND_LO without a same-cycle accept, is dropped: no capture, and DROP_CNT increments, saturating at 255.
- The frame in flight is unaffected by a drop.
- CH_SEL changes between ticks have no effect on a frame in flight.

Test Plan (CLK_HZ=100, SAMPLE_HZ=10, DIV=10 unless stated):
1. Reset release, ENABLE=1, CH_SEL=3, CH3=0xABC, TX_READY=1 -> tick at cycle 10; bytes 0xAA then 0x3C on consecutive cycles; BUSY high 2 cycles; DROP_CNT=0.
2. TX_READY=0 for 5 cycles after byte0 is offered -> TX_DATA held at byte0 and TX_VALID held at 1 throughout; byte1 follows 1 cycle after TX_READY rises.
3. TX_READY tied 0 for 35 cycles after first tick -> DROP_CNT=3; after TX_READY=1 only the original frame is sent; next frame starts at the next tick.
4. Stall so the byte1 accept lands exactly on a tick cycle -> new byte0 offered the following cycle with no IDLE gap; DROP_CNT unchanged.
5. CH_SEL=7, CH7=0xFFF, then CH_SEL=0, CH0=0x000 on alternate ticks -> frames 0xBF,0x3F and 0x80,0x00.
6. Assert RESET while TX_VALID=1 in SEND_LO -> TX_VALID=0 and TX_DATA=0x00 before the next clock edge; after release, first frame arrives at cycle DIV with correct byte0.

Source files
------------

// File: rtl/adc_uart_framer.sv
// Purpose: samples one of eight 12-bit ADC channels at a fixed rate and packs it into a 2-byte sync-flagged frame for the UART.
// Latency: byte0 is offered 1 cycle after the sample tick; byte1 follows 1 cycle after byte0 is accepted.
// Backpressure: bytes are held while TX_READY is low; ticks arriving while a frame is still pending are dropped and counted.
module adc_uart_framer #(
    parameter int CLK_HZ    = 50000000,
    parameter int SAMPLE_HZ = 8000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [2:0]  CH_SEL,
    input  logic [11:0] CH0,
    input  logic [11:0] CH1,
    input  logic [11:0] CH2,
    input  logic [11:0] CH3,
    input  logic [11:0] CH4,
    input  logic [11:0] CH5,
    input  logic [11:0] CH6,
    input  logic [11:0] CH7,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        BUSY,
    output logic [7:0]  DROP_CNT
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    // A divider below 4 cannot fit a full frame between ticks.
    if (DIV < 4) begin : g_div_too_small
        $error("adc_uart_framer: CLK_HZ/SAMPLE_HZ must be at least 4");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [11:0]   sample;
    logic [11:0]   sel_val;
    logic          tick;
    logic          accept;

    assign tick   = ENABLE && (cnt == CNT_LAST);
    assign accept = TX_VALID && TX_READY;

    // Channel selected by CH_SEL at the current cycle.
    always_comb begin
        sel_val = CH0;
        case (CH_SEL)
            3'd0:    sel_val = CH0;
            3'd1:    sel_val = CH1;
            3'd2:    sel_val = CH2;
            3'd3:    sel_val = CH3;
            3'd4:    sel_val = CH4;
            3'd5:    sel_val = CH5;
            3'd6:    sel_val = CH6;
            default: sel_val = CH7;
        endcase
    end

    // Sample-rate divider: free-runs 0..DIV-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (!ENABLE) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame FSM with registered byte handshake and saturating overrun counter.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            sample   <= '0;
            TX_DATA  <= 8'h00;
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            DROP_CNT <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        sample   <= sel_val;
                        TX_DATA  <= {2'b10, sel_val[11:6]};
                        TX_VALID <= 1'b1;
                        BUSY     <= 1'b1;
                        state    <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    // byte1 is still pending even if byte0 goes now, so a tick here is lost.
                    if (tick && DROP_CNT != 8'hFF) begin
                        DROP_CNT <= DROP_CNT + 8'd1;
                    end
                    if (accept) begin
                        TX_DATA <= {2'b00, sample[5:0]};
                        state   <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (accept) begin
                        if (tick) begin
                            // Back-to-back frame: the line frees up on the tick cycle itself.
                            sample  <= sel_val;
                            TX_DATA <= {2'b10, sel_val[11:6]};
                            state   <= SEND_HI;
                        end else begin
                            TX_VALID <= 1'b0;
                            BUSY     <= 1'b0;
                            state    <= IDLE;
                        end
                    end else if (tick && DROP_CNT != 8'hFF) begin
                        DROP_CNT <= DROP_CNT + 8'd1;
                    end
                end
                default: begin
                    TX_VALID <= 1'b0;
                    BUSY     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_uart_framer.sv
// Bench for adc_uart_framer at CLK_HZ=100, SAMPLE_HZ=10 (DIV=10).
// Reference model: a queue of bytes still owed to the UART plus a drop count.
// Directed scenarios first, then a randomized phase with the same model.
module tb_adc_uart_framer;

    localparam int DIV = 10;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic [2:0]  CH_SEL = 3'd0;
    logic [11:0] ch [8];
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b0;
    logic        BUSY;
    logic [7:0]  DROP_CNT;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] q[$];
    int m_drop = 0;
    int m_run  = 0;

    adc_uart_framer #(.CLK_HZ(100), .SAMPLE_HZ(10)) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .ENABLE  (ENABLE),
        .CH_SEL  (CH_SEL),
        .CH0     (ch[0]),
        .CH1     (ch[1]),
        .CH2     (ch[2]),
        .CH3     (ch[3]),
        .CH4     (ch[4]),
        .CH5     (ch[5]),
        .CH6     (ch[6]),
        .CH7     (ch[7]),
        .TX_DATA (TX_DATA),
        .TX_VALID(TX_VALID),
        .TX_READY(TX_READY),
        .BUSY    (BUSY),
        .DROP_CNT(DROP_CNT)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge of the abstract framer: bytes leave on accept, a tick
    // either queues a fresh frame (line fully free) or counts a drop.
    task automatic model_edge();
        logic tick;
        logic [11:0] s;
        if (RESET) begin
            q.delete();
            m_drop = 0;
            m_run  = 0;
            return;
        end
        tick  = ENABLE && ((m_run % DIV) == DIV - 1);
        m_run = ENABLE ? m_run + 1 : 0;
        if (q.size() != 0 && TX_READY) void'(q.pop_front());
        if (tick) begin
            if (q.size() == 0) begin
                s = ch[CH_SEL];
                q.push_back({2'b10, s[11:6]});
                q.push_back({2'b00, s[5:0]});
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
    endtask

    task automatic compare();
        chk("valid", 32'(TX_VALID), 32'(q.size() != 0));
        chk("busy", 32'(BUSY), 32'(q.size() != 0));
        if (q.size() != 0) chk("data", 32'(TX_DATA), 32'(q[0]));
        chk("drop", 32'(DROP_CNT), 32'(m_drop));
    endtask

    task automatic step(input logic en, input logic [2:0] sel, input logic rdy);
        @(negedge CLOCK);
        ENABLE   = en;
        CH_SEL   = sel;
        TX_READY = rdy;
        @(posedge CLOCK);
        model_edge();
        #1;
        compare();
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge, released before the next negedge.
    task automatic do_reset();
        #2;
        RESET = 1'b1;
        #1;
        chk("rst_valid", 32'(TX_VALID), 32'd0);
        chk("rst_data", 32'(TX_DATA), 32'h00);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_drop", 32'(DROP_CNT), 32'd0);
        q.delete();
        m_drop = 0;
        m_run  = 0;
        @(posedge CLOCK);
        #2;
        RESET = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ch[i] = 12'h000;

        // Power-on reset
        repeat (3) @(posedge CLOCK);
        #1;
        chk("por_valid", 32'(TX_VALID), 32'd0);
        chk("por_data", 32'(TX_DATA), 32'h00);
        chk("por_busy", 32'(BUSY), 32'd0);
        chk("por_drop", 32'(DROP_CNT), 32'd0);
        #1;
        RESET = 1'b0;

        // Plan 1: first frame at cycle DIV, back-to-back bytes
        ch[3] = 12'hABC;
        for (int k = 1; k <= 9; k++) step(1'b1, 3'd3, 1'b1);
        chk("t1_idle_before_tick", 32'(TX_VALID), 32'd0);
        step(1'b1, 3'd3, 1'b1);
        chk("t1_byte0", 32'(TX_DATA), 32'hAA);
        step(1'b1, 3'd3, 1'b1);
        chk("t1_byte1", 32'(TX_DATA), 32'h3C);
        step(1'b1, 3'd3, 1'b1);
        chk("t1_done", 32'(TX_VALID), 32'd0);

        // Plan 2: 5-cycle stall on byte0
        do_reset();
        for (int k = 1; k <= 10; k++) step(1'b1, 3'd3, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 3'd3, 1'b0);
            chk("t2_hold", 32'(TX_DATA), 32'hAA);
        end
        step(1'b1, 3'd3, 1'b1);
        chk("t2_byte1", 32'(TX_DATA), 32'h3C);
        step(1'b1, 3'd3, 1'b1);

        // Plan 3: 35-cycle stall -> 3 drops, then only the original frame
        do_reset();
        for (int k = 1; k <= 10; k++) step(1'b1, 3'd3, 1'b0);
        for (int k = 0; k < 35; k++) step(1'b1, 3'd3, 1'b0);
        chk("t3_drops", 32'(DROP_CNT), 32'd3);
        for (int k = 0; k < 20; k++) step(1'b1, 3'd3, 1'b1);

        // Plan 4: byte1 accepted on a tick cycle -> next frame without gap
        do_reset();
        ch[2] = 12'h5A3;
        for (int k = 1; k <= 17; k++) step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd2, 1'b1);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd2, 1'b1);
        chk("t4_nogap_valid", 32'(TX_VALID), 32'd1);
        chk("t4_nogap_byte0", 32'(TX_DATA), 32'h96);
        chk("t4_no_drop", 32'(DROP_CNT), 32'd0);
        for (int k = 0; k < 5; k++) step(1'b1, 3'd2, 1'b1);

        // Plan 5: extreme values on alternate ticks
        do_reset();
        ch[7] = 12'hFFF;
        ch[0] = 12'h000;
        for (int k = 1; k <= 10; k++) step(1'b1, 3'd7, 1'b1);
        chk("t5_ff_b0", 32'(TX_DATA), 32'hBF);
        step(1'b1, 3'd0, 1'b1);
        chk("t5_ff_b1", 32'(TX_DATA), 32'h3F);
        for (int k = 12; k <= 20; k++) step(1'b1, 3'd0, 1'b1);
        chk("t5_00_b0", 32'(TX_DATA), 32'h80);
        step(1'b1, 3'd7, 1'b1);
        chk("t5_00_b1", 32'(TX_DATA), 32'h00);

        // Plan 6: reset while byte1 is pending, then a clean first frame
        do_reset();
        ch[3] = 12'hABC;
        for (int k = 1; k <= 11; k++) step(1'b1, 3'd3, 1'b1);
        chk("t6_in_lo", 32'(TX_DATA), 32'h3C);
        do_reset();
        for (int k = 1; k <= 10; k++) step(1'b1, 3'd3, 1'b0);
        chk("t6_after_rst_b0", 32'(TX_DATA), 32'hAA);

        // DROP_CNT saturation: ~270 ticks with the UART stalled
        for (int k = 0; k < 270 * DIV; k++) step(1'b1, 3'd3, 1'b0);
        chk("sat_drop", 32'(DROP_CNT), 32'd255);
        for (int k = 0; k < 4; k++) step(1'b1, 3'd3, 1'b1);

        // Enable low parks the divider; an in-flight frame still completes
        do_reset();
        for (int k = 1; k <= 10; k++) step(1'b1, 3'd3, 1'b0);
        for (int k = 0; k < 30; k++) step(1'b0, 3'd3, (k > 3) ? 1'b1 : 1'b0);

        // Randomized phase
        begin
            logic en = 1'b1;
            int stall_pct = 20;
            for (int c = 0; c < 6000; c++) begin
                if ($urandom_range(0, 199) == 0) en = ~en;
                if ((c % 64) == 0) stall_pct = $urandom_range(0, 95);
                if ($urandom_range(0, 7) == 0) ch[$urandom_range(0, 7)] = 12'($urandom);
                step(en, 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 99) >= stall_pct) ? 1'b1 : 1'b0);
                if ($urandom_range(0, 999) == 0) do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
